// File: rtl/ppwm_ex_mc.sv
// rtl/ppwm_ex_mc.sv - multi-channel time-multiplexed PWM program executor
//
// One shared execute datapath serves NUM_CH channels in fixed round-robin
// slots. Each channel keeps its own PC, state, compare flag, scratch
// register and PWM value.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start_i            one-cycle pulse marking a new PWM period
//   ch_en_i            per-channel enable
//   global_counter_i   upper value of the global PWM counter
//   instr_i            instruction fetched at {ch_o, pc_o}, same cycle
//   ch_o, pc_o         fetch address: slot owner and its PC
//   pwm_value_o        channel c at [c*COUNTER_WIDTH +: COUNTER_WIDTH]
//   overrun_o          sticky per channel: start arrived while executing
//
// Build option: define PPWM_EX_SATURATE_EN to make ADD saturate instead of wrap.

module ppwm_ex_mc #(
    parameter int COUNTER_WIDTH = 8,
    parameter int INSTR_WIDTH   = 8,
    parameter int PC_WIDTH      = 4,
    parameter int NUM_CH        = 4,
    localparam int ChW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic [NUM_CH-1:0]               ch_en_i,
    input  logic [COUNTER_WIDTH-1:0]        global_counter_i,
    input  logic [INSTR_WIDTH-1:0]          instr_i,
    output logic [ChW-1:0]                  ch_o,
    output logic [PC_WIDTH-1:0]             pc_o,
    output logic [NUM_CH*COUNTER_WIDTH-1:0] pwm_value_o,
    output logic [NUM_CH-1:0]               overrun_o
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_SET    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_SHIFT  = 3'd3;
    localparam logic [2:0] OP_WAIT   = 3'd4;
    localparam logic [2:0] OP_JUMP   = 3'd5;
    localparam logic [2:0] OP_CMP    = 3'd6;
    localparam logic [2:0] OP_BRANCH = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_LAST   = '1;
    localparam logic [ChW-1:0]      SLOT_LAST = ChW'(NUM_CH - 1);

    logic [ChW-1:0]           slot_q, slot_d;
    state_e                   state_q [NUM_CH];
    state_e                   state_d [NUM_CH];
    logic [PC_WIDTH-1:0]      pc_q    [NUM_CH];
    logic [PC_WIDTH-1:0]      pc_d    [NUM_CH];
    logic                     flag_q  [NUM_CH];
    logic                     flag_d  [NUM_CH];
    logic [COUNTER_WIDTH-1:0] reg_q   [NUM_CH];
    logic [COUNTER_WIDTH-1:0] reg_d   [NUM_CH];
    logic [COUNTER_WIDTH-1:0] pwm_q   [NUM_CH];
    logic [COUNTER_WIDTH-1:0] pwm_d   [NUM_CH];
    logic [NUM_CH-1:0]        ovr_q, ovr_d;

    // Instruction decode; the offset overlaps the tgt bit and is sign-extended.
    logic [2:0]               op;
    logic                     tgt_pwm;
    logic [COUNTER_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]      off;

    assign op      = instr_i[2:0];
    assign tgt_pwm = instr_i[3];
    assign imm     = COUNTER_WIDTH'(instr_i[INSTR_WIDTH-1:4]);
    assign off     = PC_WIDTH'($signed(instr_i[INSTR_WIDTH-1:3]));

    // Shared datapath operating on the channel that owns the current slot.
    logic [COUNTER_WIDTH-1:0] cur_tgt;
    logic [COUNTER_WIDTH-1:0] alu_res;
    logic [COUNTER_WIDTH:0]   add_full;
    logic [PC_WIDTH-1:0]      cur_pc;
    logic [PC_WIDTH-1:0]      pc_seq;
    logic [PC_WIDTH-1:0]      pc_rel;

    always_comb begin
        cur_tgt  = tgt_pwm ? pwm_q[slot_q] : reg_q[slot_q];
        cur_pc   = pc_q[slot_q];
        pc_seq   = cur_pc + PC_WIDTH'(1);
        pc_rel   = cur_pc + off;
        add_full = {1'b0, cur_tgt} + {1'b0, imm};
        alu_res  = cur_tgt;
        case (op)
            OP_SET:   alu_res = imm;
`ifdef PPWM_EX_SATURATE_EN
            OP_ADD:   alu_res = add_full[COUNTER_WIDTH] ? '1 : add_full[COUNTER_WIDTH-1:0];
`else
            OP_ADD:   alu_res = add_full[COUNTER_WIDTH-1:0];
`endif
            OP_SHIFT: alu_res = imm[0] ? (cur_tgt << 1) : (cur_tgt >> 1);
            default:  alu_res = cur_tgt;
        endcase
    end

    // Next-state logic for the slot counter and every channel.
    always_comb begin
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + ChW'(1);
        ovr_d  = ovr_q;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            pc_d[c]    = pc_q[c];
            flag_d[c]  = flag_q[c];
            reg_d[c]   = reg_q[c];
            pwm_d[c]   = pwm_q[c];
            if (!ch_en_i[c]) begin
                state_d[c] = ST_IDLE;
                pc_d[c]    = '0;
            end else if (state_q[c] != ST_EXEC) begin
                // A start in the channel's own slot only arms it; no execution.
                if (start_i) begin
                    state_d[c] = ST_EXEC;
                end
            end else begin
                if (start_i) begin
                    ovr_d[c] = 1'b1;
                end
                if (slot_q == ChW'(c)) begin
                    pc_d[c] = pc_seq;
                    if (cur_pc == PC_LAST) begin
                        state_d[c] = ST_IDLE;
                    end
                    case (op)
                        OP_SET, OP_ADD, OP_SHIFT: begin
                            if (tgt_pwm) pwm_d[c] = alu_res;
                            else         reg_d[c] = alu_res;
                        end
                        OP_WAIT:   state_d[c] = ST_WAIT;
                        OP_JUMP:   pc_d[c] = pc_rel;
                        OP_CMP:    flag_d[c] = (global_counter_i < cur_tgt);
                        OP_BRANCH: if (flag_q[c]) pc_d[c] = pc_rel;
                        default:   ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '0;
            ovr_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                pc_q[c]    <= '0;
                flag_q[c]  <= 1'b0;
                reg_q[c]   <= '0;
                pwm_q[c]   <= '0;
            end
        end else begin
            slot_q <= slot_d;
            ovr_q  <= ovr_d;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                pc_q[c]    <= pc_d[c];
                flag_q[c]  <= flag_d[c];
                reg_q[c]   <= reg_d[c];
                pwm_q[c]   <= pwm_d[c];
            end
        end
    end

    always_comb begin
        ch_o      = slot_q;
        pc_o      = pc_q[slot_q];
        overrun_o = ovr_q;
        for (int c = 0; c < NUM_CH; c++) begin
            pwm_value_o[c*COUNTER_WIDTH +: COUNTER_WIDTH] = pwm_q[c];
        end
    end

endmodule

// File: doc/ppwm_ex_mc.md
# ppwm_ex_mc

Multi-channel successor to the single-channel PWM program executor. One shared execution datapath is time-multiplexed over `NUM_CH` channels in fixed round-robin slots. Each channel has its own PC, state, compare flag, scratch register and PWM value. The block fetches from a single shared instruction memory port and sits between the program memory and the per-channel PWM comparators.

## Interface
- `COUNTER_WIDTH`, 8, width of the global counter, PWM value and register.
- `INSTR_WIDTH`, 8, instruction width; must be ≥ 5.
- `PC_WIDTH`, 4, per-channel program counter width.
- `NUM_CH`, 4, channel count, ≥ 1; `ChW = max(1, $clog2(NUM_CH))`.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start_i`  in  1  start of new PWM period, one-cycle pulse
- `ch_en_i`  in  NUM_CH  per-channel enable
- `global_counter_i`  in  COUNTER_WIDTH  upper value of global counter
- `instr_i`  in  INSTR_WIDTH  instruction at {`ch_o`, `pc_o`}, valid combinationally in the same cycle
- `ch_o`  out  ChW  channel owning the current slot
- `pc_o`  out  PC_WIDTH  PC of channel `ch_o`
- `pwm_value_o`  out  NUM_CH*COUNTER_WIDTH  channel c at bits [c*COUNTER_WIDTH +: COUNTER_WIDTH]
- `overrun_o`  out  NUM_CH  sticky: `start_i` arrived while the channel was in StExec

## Operation
- **Slot counter** `slot_q`:
  - Advances 0..NUM_CH-1 every cycle, then wraps; `ch_o = slot_q`.
  - A channel executes only in its own slot, and only if it is in StExec.
- **Per-channel states:** StIdle, StExec, StWait.
  - StIdle/StWait → StExec on `start_i`. This is evaluated every cycle for every channel, independent of slot.
  - In StWait the PC is kept.
- **Instruction fields:**
  - op = [2:0]
  - tgt = [3] (0 = REG, 1 = PWM)
  - imm = [INSTR_WIDTH-1:4], zero-extended
  - off = [INSTR_WIDTH-1:3], signed two's complement, sign-extended to PC_WIDTH
- **Opcodes** (ppwm_pkg encoding). PC becomes pc+1 unless stated otherwise.
  - 0 NOP.
  - 1 SET: tgt ← imm.
  - 2 ADD: tgt ← tgt + imm, modulo 2^COUNTER_WIDTH.
  - 3 SHIFT: imm[0]=1 shifts left, imm[0]=0 shifts right; vacated bit is 0.
  - 4 WAIT: → StWait.
  - 5 JUMP: pc ← pc + off.
  - 6 CMP: flag ← (`global_counter_i` < tgt). The flag is both set and cleared.
  - 7 BRANCH: if flag, pc ← pc + off.
- **PC arithmetic:** all PC arithmetic is modulo 2^PC_WIDTH, so backward jumps are legal.
- **End of program:** executing at pc = all-ones moves the channel to StIdle, with PC per the rules above (wraps to 0 on sequential flow).
  - WAIT at pc = all-ones goes to StWait instead (WAIT wins).
- **Channel disable:** `ch_en_i[c]=0` forces the channel to StIdle with pc 0 next cycle.
  - A disabled channel ignores `start_i` and does not execute.
  - Its register, PWM value and flag are retained.
- **Overrun:**
  - `start_i` while the channel is in StExec sets `overrun_o[c]`, which clears only on reset.
  - The channel stays in StExec, PC unchanged by the start.
- **Start in the channel's own slot while in StIdle/StWait:** the state change takes effect next cycle, and no instruction executes in that slot.

## Timing
- **Reset values:** `slot_q`=0, all states StIdle, PCs 0, flags 0, registers 0, `pwm_value_o`=0, `overrun_o`=0; `ch_o`=0, `pc_o`=0.
- **Execution:** in its slot, the channel's instruction is read combinationally and its results are registered at the clock edge. `pwm_value_o` updates one cycle after the executing slot.
- **Throughput:** each channel executes at most one instruction per NUM_CH cycles.
- **First execution:** with `start_i` at cycle t, a channel first executes at its first slot ≥ t+1.
- **Reset mid-operation:** all state returns to the reset values on the next edge; no partial update.

## Configuration
- `PPWM_EX_SATURATE_EN` defined: ADD saturates at 2^COUNTER_WIDTH-1 instead of wrapping.
- Undefined: ADD wraps modulo 2^COUNTER_WIDTH.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with random inputs. Expect all outputs 0, and `ch_o` sequence 0,1,2,3,0 after release.
- **SET/ADD on ch1** (others disabled): program SET PWM 5, ADD PWM 3, WAIT, then `start_i`. Expect ch1 PWM value 8 one cycle after its second executing slot, and the channel parked in StWait at pc 3.
- **CMP/BRANCH with backward jump:** counter=10, PWM=8, CMP PWM then BRANCH off=-2. Expect the flag to clear and execution to fall through. Then with counter=5, expect the flag set and the PC to go back 2.
- **Wrap and ADD overflow:** program at pc 15 is NOP. Expect StIdle and pc 0. Separately, PWM=254 then ADD 3: expect 1 without the macro, 255 with `PPWM_EX_SATURATE_EN`.
- **Overrun and disable:** pulse `start_i` while ch2 is in StExec; expect `overrun_o`=4'b0100 and execution continuing. Then drop `ch_en_i[2]`; expect StIdle, pc 0 and PWM value retained.
- **Slot isolation:** all 4 channels run distinct SET values. Expect each `pwm_value_o` lane to change only in the cycle after its own slot.
